signed_div8: RTL

SIGNED_DIV8 -- requirements
Module: signed_div8

---
 rtl/signed_div_pkg.sv | 19 +
 rtl/signed_div8_if.sv | 29 ++
 rtl/sdiv_abs.sv | 24 ++
 rtl/signed_div8.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/signed_div_pkg.sv
// signed_div_pkg: shared constants and FSM encoding for the signed 8-bit
// restoring divider.
//   WIDTH - operand/result width in bits
//   STEPS - restoring-division steps per operation (one per quotient bit)
//   CNT_W - width of the step counter (must hold 0..STEPS)
//   state_t - divider control FSM states
package signed_div_pkg;

  localparam int WIDTH = 8;
  localparam int STEPS = 8;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/signed_div8_if.sv
// signed_div8_if: request/result bundle of the signed divider.
//   start, dividend, divisor                  - request (master -> slave)
//   busy, done, quotient, remainder,
//   div_by_zero, overflow                     - status/result (slave -> master)
interface signed_div8_if #(
  parameter int WIDTH = signed_div_pkg::WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/sdiv_abs.sv
// sdiv_abs: combinational two's-complement to sign/magnitude conversion.
//   value - signed WIDTH-bit input
//   mag   - WIDTH+1-bit magnitude (one extra bit so the most negative value
//           converts exactly)
//   neg   - sign of value
module sdiv_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH:0]   mag,
  output logic             neg
);

  // Negate in WIDTH+1 bits so that -2^(WIDTH-1) yields +2^(WIDTH-1).
  always_comb begin
    neg = value[WIDTH-1];
    if (neg) begin
      mag = {1'b0, ~value} + (WIDTH+1)'(1);
    end else begin
      mag = {1'b0, value};
    end
  end

endmodule

// File: rtl/signed_div8.sv
// signed_div8: multi-cycle signed divider (restoring, one quotient bit per
// cycle on sign/magnitude operands, sign correction at the end).
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of signed_div8_if: start/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero/overflow out
// Quotient truncates toward zero, remainder takes the dividend's sign.
// Divide by zero returns quotient -1 and remainder = dividend.
module signed_div8
  import signed_div_pkg::*;
#(
  parameter int WIDTH = signed_div_pkg::WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  signed_div8_if.slave  bus
);

  state_t           state_r;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt_r;

  // Working registers: rem_r is the partial remainder, q_r starts as the
  // dividend magnitude and shifts quotient bits in from the right.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH:0]   dvs_mag_r;
  logic             dvd_neg_r;
  logic             quo_neg_r;
  logic [WIDTH-1:0] dvd_raw_r;
  logic             zero_pend_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;
  logic             ovf_r;

  logic [WIDTH:0]   dvd_mag_s;
  logic [WIDTH:0]   dvs_mag_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic             divisor_zero_s;
  logic             last_step_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;
  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  sdiv_abs #(.WIDTH(WIDTH)) u_abs_dvd (
    .value (bus.dividend),
    .mag   (dvd_mag_s),
    .neg   (dvd_neg_s)
  );

  sdiv_abs #(.WIDTH(WIDTH)) u_abs_dvs (
    .value (bus.divisor),
    .mag   (dvs_mag_s),
    .neg   (dvs_neg_s)
  );

  assign divisor_zero_s = (bus.divisor == {WIDTH{1'b0}});
  assign last_step_s    = (cnt_r == CNT_W'(STEPS));

  // One restoring step. The partial remainder stays below the divisor
  // (at most 2^(WIDTH-1)), so shifted_s < 2^WIDTH and the top bit of the
  // WIDTH+1-bit difference is exactly the borrow.
  always_comb begin
    shifted_s = {rem_r, q_r[WIDTH-1]};
    diff_s    = shifted_s - dvs_mag_r;
    fits_s    = ~diff_s[WIDTH];
    if (fits_s) begin
      rem_nx_s = diff_s[WIDTH-1:0];
    end else begin
      rem_nx_s = shifted_s[WIDTH-1:0];
    end
  end

  // Sign correction applied when the last step has completed.
  always_comb begin
    if (quo_neg_r) begin
      quo_fix_s = -q_r;
    end else begin
      quo_fix_s = q_r;
    end
    if (dvd_neg_r) begin
      rem_fix_s = -rem_r;
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // Next-state logic. A zero divisor spends one non-busy cycle in IDLE
  // (zero_pend_r) so its done pulse follows the accepting edge by one edge.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (zero_pend_r) begin
          state_nx = ST_DONE;
        end else if (bus.start && !divisor_zero_s) begin
          state_nx = ST_CALC;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_step_s) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_CALC;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath, step counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      dvs_mag_r   <= {(WIDTH+1){1'b0}};
      dvd_neg_r   <= 1'b0;
      quo_neg_r   <= 1'b0;
      dvd_raw_r   <= {WIDTH{1'b0}};
      zero_pend_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      busy_r <= (state_nx == ST_CALC);
      done_r <= (state_nx == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (zero_pend_r) begin
            zero_pend_r <= 1'b0;
            quotient_r  <= {WIDTH{1'b1}};
            remainder_r <= dvd_raw_r;
            dbz_r       <= 1'b1;
          end else if (bus.start) begin
            // Bit WIDTH of the dividend magnitude seeds the partial
            // remainder; the low bits are consumed one per step.
            rem_r       <= {{(WIDTH-1){1'b0}}, dvd_mag_s[WIDTH]};
            q_r         <= dvd_mag_s[WIDTH-1:0];
            dvs_mag_r   <= dvs_mag_s;
            dvd_neg_r   <= dvd_neg_s;
            quo_neg_r   <= dvd_neg_s ^ dvs_neg_s;
            dvd_raw_r   <= bus.dividend;
            zero_pend_r <= divisor_zero_s;
            cnt_r       <= {CNT_W{1'b0}};
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
          end
        end
        ST_CALC: begin
          if (last_step_s) begin
            quotient_r  <= quo_fix_s;
            remainder_r <= rem_fix_s;
            // A positive quotient with its top bit set only arises from
            // -2^(WIDTH-1) / -1, which does not fit.
            ovf_r       <= ~quo_neg_r & q_r[WIDTH-1];
          end else begin
            rem_r <= rem_nx_s;
            q_r   <= {q_r[WIDTH-2:0], fits_s};
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;

endmodule
